// File: rtl/crossroad1_core_leds_pkg.sv
// rtl/crossroad1_core_leds_pkg.sv - register map, reset values and bus widths for the LED output port
package crossroad1_core_leds_pkg;

    localparam int RD_W = 32;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] ADDR_OUTSET       = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd3;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS       = 3'd5;

    localparam logic [RD_W-1:0] RST_REG   = '0;
    localparam logic            RST_PHASE = 1'b1;

endpackage

// File: rtl/crossroad1_core_leds_if.sv
// rtl/crossroad1_core_leds_if.sv - Avalon-MM slave bus bundle for the LED output port
interface crossroad1_core_leds_if;
    import crossroad1_core_leds_pkg::*;

    logic [2:0]      address;
    logic            chipselect;
    logic            write_n;
    logic [RD_W-1:0] writedata;
    logic [RD_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/crossroad1_core_blink_timer.sv
// rtl/crossroad1_core_blink_timer.sv - half-period counter producing the blink phase
import crossroad1_core_leds_pkg::*;

module crossroad1_core_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;

    // A period write restarts the on-phase even on a terminal-count edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= RST_PHASE;
        end else if (period_wr || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period - PERIOD_W'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/crossroad1_core_leds.sv
// rtl/crossroad1_core_leds.sv - LED output port top; blink hardware under CROSSROAD1_LEDS_BLINK_EN
import crossroad1_core_leds_pkg::*;

module crossroad1_core_leds #(
    parameter int WIDTH    = 6,
    parameter int PERIOD_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    crossroad1_core_leds_if.slave   bus,
    output logic [WIDTH-1:0]        out_port
);

    logic             wr;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] blink_off;
    logic [RD_W-1:0]  rd_next;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= WIDTH'(RST_REG);
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:     data <= wd;
                ADDR_OUTSET:   data <= data | wd;
                ADDR_OUTCLEAR: data <= data & ~wd;
                default:       data <= data;
            endcase
        end
    end

`ifdef CROSSROAD1_LEDS_BLINK_EN
    logic [WIDTH-1:0]    mask;
    logic [PERIOD_W-1:0] period;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr && bus.address == ADDR_BLINK_PERIOD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask   <= WIDTH'(RST_REG);
            period <= PERIOD_W'(RST_REG);
        end else if (wr) begin
            if (bus.address == ADDR_BLINK_MASK) mask <= wd;
            if (period_wr) period <= bus.writedata[PERIOD_W-1:0];
        end
    end

    crossroad1_core_blink_timer #(.PERIOD_W(PERIOD_W)) u_blink_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (period),
        .period_wr (period_wr),
        .phase     (phase)
    );

    assign blink_off = mask & {WIDTH{~phase}};

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:         rd_next = RD_W'(data);
            ADDR_BLINK_MASK:   rd_next = RD_W'(mask);
            ADDR_BLINK_PERIOD: rd_next = RD_W'(period);
            ADDR_STATUS:       rd_next = RD_W'(phase);
            default:           rd_next = '0;
        endcase
    end
`else
    assign blink_off = '0;

    always_comb begin
        rd_next = '0;
        if (bus.address == ADDR_DATA) rd_next = RD_W'(data);
    end
`endif

    // Read data is sampled every clock from the address, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port     <= WIDTH'(RST_REG);
            bus.readdata <= RST_REG;
        end else begin
            out_port     <= data & ~blink_off;
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_crossroad1_core_leds.sv
// tb/tb_crossroad1_core_leds.sv - directed self-checking bench for crossroad1_core_leds
module tb_crossroad1_core_leds;

    logic       clk;
    logic       reset;
    logic [5:0] out_port;
    int         tests;
    int         fails;
    logic [31:0] rv;

    crossroad1_core_leds_if bus ();

    crossroad1_core_leds #(.WIDTH(6), .PERIOD_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tasks start and end at a falling edge; the write lands on the rising edge in between.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        @(negedge clk);
        v = bus.readdata;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_out", 32'(out_port), 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rv);
`ifdef CROSSROAD1_LEDS_BLINK_EN
            check($sformatf("reset_rd%0d", a), rv, (a == 5) ? 32'h1 : 32'h0);
`else
            check($sformatf("reset_rd%0d", a), rv, 32'h0);
`endif
        end

        bus.address = 3'd0;
        @(negedge clk);
        wr(3'd0, 32'h21);
        check("rd_same_cycle_old", bus.readdata, 32'h0);
        check("out_latency", 32'(out_port), 32'h0);
        @(negedge clk);
        check("out_data21", 32'(out_port), 32'h21);
        rd(3'd0, rv);
        check("rd_data21", rv, 32'h21);

        wr(3'd2, 32'h0C);
        rd(3'd0, rv);
        check("outset", rv, 32'h2D);
        wr(3'd3, 32'h01);
        rd(3'd0, rv);
        check("outclear", rv, 32'h2C);
        rd(3'd2, rv);
        check("rd_outset0", rv, 32'h0);
        rd(3'd3, rv);
        check("rd_outclear0", rv, 32'h0);

        wr(3'd0, 32'h3F);
        wr(3'd1, 32'hFFFF_FF12);
        rd(3'd1, rv);
`ifdef CROSSROAD1_LEDS_BLINK_EN
        check("rd_mask", rv, 32'h12);
        wr(3'd4, 32'h4);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("blink_c%0d", i), 32'(out_port), (((i - 1) / 4) % 2 == 1) ? 32'h2D : 32'h3F);
        end
        rd(3'd4, rv);
        check("rd_period", rv, 32'h4);

        // Restart, then rewrite the period exactly on the terminal-count edge.
        wr(3'd4, 32'h4);
        repeat (3) @(negedge clk);
        check("pre_tc_on", 32'(out_port), 32'h3F);
        wr(3'd4, 32'h4);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("tc_rewrite_c%0d", i), 32'(out_port), (i == 5) ? 32'h2D : 32'h3F);
        end

        wr(3'd4, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("period0_c%0d", i), 32'(out_port), 32'h3F);
        end
        rd(3'd5, rv);
        check("period0_status", rv, 32'h1);
        wr(3'd4, 32'h3);
        repeat (5) @(negedge clk);
`else
        check("rd_mask_off", rv, 32'h0);
        wr(3'd4, 32'h4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("noblink_c%0d", i), 32'(out_port), 32'h3F);
        end
        rd(3'd4, rv);
        check("rd_period_off", rv, 32'h0);
        rd(3'd5, rv);
        check("rd_status_off", rv, 32'h0);
`endif

        bus.address    = 3'd0;
        bus.writedata  = 32'h15;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", 32'(out_port), 32'h0);
        check("async_rst_rd", bus.readdata, 32'h0);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_out", 32'(out_port), 32'h0);
        rd(3'd0, rv);
        check("post_rst_data", rv, 32'h0);
        rd(3'd1, rv);
        check("post_rst_mask", rv, 32'h0);
        rd(3'd4, rv);
        check("post_rst_period", rv, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
